// File: rtl/vram_slot_arbiter.sv
// rtl/vram_slot_arbiter.sv - 8-phase VRAM slot scheduler between layer tile fetch and one CPU access
// Optional feature macro: VRAM_CPU_WAIT_EN (drives cpu_wait while a CPU access is outstanding)
module vram_slot_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int NLAYERS = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fetch_en,
  output logic [1:0]    fetch_sel,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_valid,
  output logic [2:0]    fetch_tag,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [2:0]    phase,
  output logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_wdata,
  input  logic [DW-1:0] vram_data,
  output logic          vram_rd_en,
  output logic          vram_we
);

  localparam logic [3:0] FETCH_PHASES = 4'(2 * NLAYERS);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_BUS, C_DONE} cpu_state_t;

  cpu_state_t    cpu_state;
  logic [2:0]    phase_next;
  logic          next_is_fetch;
  logic          fetch_bus;
  logic [2:0]    fetch_bus_tag;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  assign phase_next    = phase + 3'd1;
  assign next_is_fetch = fetch_en && ({1'b0, phase_next} < FETCH_PHASES);
  assign fetch_sel     = phase_next[2:1];

`ifdef VRAM_CPU_WAIT_EN
  assign cpu_wait = !reset && cpu_req && (cpu_state != C_DONE);
`else
  assign cpu_wait = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase         <= 3'd7;
      cpu_state     <= C_IDLE;
      fetch_bus     <= 1'b0;
      fetch_bus_tag <= 3'd0;
      fetch_data    <= '0;
      fetch_valid   <= 1'b0;
      fetch_tag     <= 3'd0;
      cpu_rdata     <= '0;
      cpu_ack       <= 1'b0;
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      vram_addr     <= '0;
      vram_wdata    <= '0;
      vram_rd_en    <= 1'b0;
      vram_we       <= 1'b0;
    end else begin
      phase <= phase_next;

      // A fetch issued last edge completes now; {layer, half} is just the phase number.
      fetch_valid <= fetch_bus;
      if (fetch_bus) begin
        fetch_data <= vram_data;
        fetch_tag  <= fetch_bus_tag;
      end
      fetch_bus     <= next_is_fetch;
      fetch_bus_tag <= phase_next;

      vram_rd_en <= 1'b0;
      vram_we    <= 1'b0;
      cpu_ack    <= 1'b0;
      if (next_is_fetch) begin
        vram_addr  <= fetch_addr;
        vram_rd_en <= 1'b1;
      end

      case (cpu_state)
        C_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            cpu_state <= C_WAIT;
          end
        end
        C_WAIT: begin
          // Only claim the bus for a slot the fetch side cannot use.
          if (!next_is_fetch) begin
            vram_addr  <= req_addr;
            vram_we    <= req_we;
            vram_rd_en <= !req_we;
            vram_wdata <= req_wdata;
            cpu_state  <= C_BUS;
          end
        end
        C_BUS: begin
          if (!req_we) cpu_rdata <= vram_data;
          cpu_ack   <= 1'b1;
          cpu_state <= C_DONE;
        end
        default: begin
          cpu_state <= C_IDLE;
        end
      endcase
    end
  end

endmodule
